dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Two-requester arbiter and access sequencer for the single-port word-organised data memory. Port 0 is the core load/store path and port 1 the debug/DMA path. The block grants requesters round-robin and sequences one memory access at a time. It generates byte strobes and replicated write data for SB/SH/SW, and it extracts and sign- or zero-extends load data for LB/LH/LW/LBU/LHU. Misaligned and out-of-range accesses return an error instead of touching memory.

Parameters:
MEM_DEPTH, 4096, number of 32-bit words in data memory
AW, 12, word-address width; must equal clog2(MEM_DEPTH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
pN_req  in  1  port N (N=0,1) request; held until pN_ack
pN_we  in  1  1=store, 0=load
pN_addr  in  32  byte address
pN_size  in  2  0=byte, 1=half, 2=word, 3=illegal
pN_uns  in  1  load zero-extend (LBU/LHU); ignored for stores and words
pN_wdata  in  32  store data, right-justified
pN_ack  out  1  one-cycle completion pulse to port N
resp_rdata  out  32  formatted load data, valid while any ack is high
resp_err  out  1  error flag, valid while any ack is high
busy  out  1  high whenever the FSM is not in IDLE
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  word address
mem_wstrb  out  4  byte-lane write strobes
mem_wdata  out  32  lane-replicated write data
mem_rdata  in  32  synchronous read data, valid the cycle after mem_en

Behaviour:
- Reset (async): state=IDLE, last_grant=1 (port 0 wins first), latched request cleared. All outputs are 0 while reset is high and at the first edge after release.
- FSM states IDLE, ACCESS, RESP. Exactly one transaction is in flight at a time.
- IDLE, rising edge with any req high:
  - Choose the winner. With one requester, grant it. With both, grant the port other than last_grant.
  - Latch we, addr, size, uns, wdata; set last_grant to the winner.
  - Legal access: go to ACCESS. Illegal access: go to RESP with err=1.
- Illegal access, any of:
  - size=3
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr[31:2] >= MEM_DEPTH
- ACCESS, one cycle: mem_en=1, mem_we=latched we, mem_addr=addr[AW+1:2], mem_wstrb and mem_wdata driven. Next edge goes to RESP.
- RESP, one cycle:
  - pN_ack=1 for the granted port only.
  - resp_err per the legality check.
  - resp_rdata is formatted combinationally from mem_rdata for a legal load, and is 0 for stores and errors.
  - Next edge goes to IDLE; the earliest new grant is at the following edge.
- Latency, req sampled at edge E0:
  - Legal access: mem_en during E0..E1, ack during E1..E2. Total 2 cycles; peak throughput is one access per 3 cycles.
  - Illegal access: ack during E0..E1, and mem_en is never asserted.
- Store formatting:
  - byte: wstrb=1<<addr[1:0], wdata={4{wdata[7:0]}}
  - half: wstrb=4'b0011<<(2*addr[1]), wdata={2{wdata[15:0]}}
  - word: wstrb=4'hF, wdata unchanged
- Load formatting: select the byte or half at the latched offset, then sign-extend unless uns=1. Word loads pass through.
- mem_wstrb and mem_wdata are 0 whenever mem_we=0 or mem_en=0.
- Requester protocol: fields must be stable from req rise until ack. If req drops early, the latched transaction still completes and ack still pulses. The requester may re-raise req in the cycle after ack.
- Reset asserted in ACCESS or RESP: mem_en and ack drop immediately, no write is issued, and the transaction is lost.

Decomposition:
- Shared package dmem_arb_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state enum
  - MEM_DEPTH default
- Sub-module dmem_lane_align (combinational):
  - store strobe and replication
  - load extract and extend
  - misalignment check
- Top-level dmem_port_arbiter owns the arbitration, the FSM, and the request latch.

Test Plan:
1. Reset, then p0 stores: SW to 0x10, wdata=0xDEADBEEF. Next cycle mem_en=1, mem_we=1, mem_addr=4, wstrb=F, mem_wdata=0xDEADBEEF. The cycle after, p0_ack=1 and resp_err=0.
2. Memory word 4 holds 0xDEADBEEF. p1 issues LB at 0x11 and gets resp_rdata=0xFFFFFFBE. LBU at 0x11 gives 0x000000BE. LHU at 0x12 gives 0x0000DEAD.
3. p0 issues SH at 0x16 with wdata=0x00001234 → mem_addr=5, wstrb=4'b1100, mem_wdata=0x12341234.
4. Both ports request continuously from reset → grants p0, p1, p0, p1; acks spaced every 3 cycles; busy stays high except in the IDLE cycles.
5. p1 issues LW at 0x12, then SB at 0x4000 → for each, mem_en stays 0, p1_ack pulses the cycle after the sampling edge, resp_err=1, resp_rdata=0.
6. Assert reset during ACCESS of an SW → mem_en drops immediately, no ack, the memory word is unchanged, and the FSM is in IDLE after release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   SZ_*      : access-size encodings carried on pN_size
//   ST_*      : arbiter FSM states
//   MEM_DEPTH_DEF : default number of 32-bit words in data memory
package dmem_arb_pkg;

    localparam int MEM_DEPTH_DEF = 4096;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for a 32-bit word memory (purely combinational).
//   i_chk_size/i_chk_off : size and byte offset of the request being granted
//   o_misalign           : size is illegal or the offset is not size-aligned
//   i_size/i_off/i_uns   : latched size, byte offset and zero-extend flag
//   i_wdata              : right-justified store data
//   o_wstrb/o_wdata      : byte strobes and lane-replicated store data
//   i_rdata              : raw word read from memory
//   o_rdata              : selected and sign/zero-extended load data
module dmem_lane_align
    import dmem_arb_pkg::*;
(
    input  size_e       i_chk_size,
    input  logic [1:0]  i_chk_off,
    output logic        o_misalign,
    input  size_e       i_size,
    input  logic [1:0]  i_off,
    input  logic        i_uns,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_misalign = 1'b0;
        case (i_chk_size)
            SZ_HALF: o_misalign = i_chk_off[0];
            SZ_WORD: o_misalign = (i_chk_off != 2'b00);
            SZ_ILL:  o_misalign = 1'b1;
            default: o_misalign = 1'b0;
        endcase
    end

    // Store side: replicate the data into every lane so the strobes alone pick the target bytes.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
        o_wstrb = 4'b0000;
        o_wdata = 32'h0;
        case (i_size)
            SZ_BYTE: begin
                o_wstrb = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_wstrb = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            SZ_WORD: begin
                o_wstrb = 4'b1111;
                o_wdata = i_wdata;
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed byte/half, then extend.
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_off)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_rdata = i_rdata;
        case (i_size)
            SZ_BYTE: o_rdata = {{24{~i_uns & w_byte[7]}}, w_byte};
            SZ_HALF: o_rdata = {{16{~i_uns & w_half[15]}}, w_half};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a single-port word memory.
// Port 0 is the core load/store path, port 1 the debug/DMA path.
//   clk, reset            : clock and asynchronous active-high reset
//   pN_req..pN_wdata      : request from port N, held until pN_ack
//   pN_ack                : one-cycle completion pulse to the granted port
//   resp_rdata, resp_err  : response data/error, valid while an ack is high
//   busy                  : FSM is not in IDLE
//   mem_*                 : synchronous memory interface (read data one cycle after mem_en)
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [31:0]   p0_addr,
    input  logic [1:0]    p0_size,
    input  logic          p0_uns,
    input  logic [31:0]   p0_wdata,
    output logic          p0_ack,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [31:0]   p1_addr,
    input  logic [1:0]    p1_size,
    input  logic          p1_uns,
    input  logic [31:0]   p1_wdata,
    output logic          p1_ack,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_wstrb,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    state_e        r_state;
    logic          r_last_grant;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [1:0]    r_off;
    size_e         r_size;
    logic          r_uns;
    logic [31:0]   r_wdata;
    logic          r_err;
    logic          r_mem_en;
    logic          r_ack0;
    logic          r_ack1;

    logic          w_req_any;
    logic          w_sel;
    logic          w_in_we;
    logic [31:0]   w_in_addr;
    size_e         w_in_size;
    logic          w_in_uns;
    logic [31:0]   w_in_wdata;
    logic          w_misalign;
    logic          w_out_of_range;
    logic          w_illegal;
    logic [3:0]    w_strb;
    logic [31:0]   w_wdata;
    logic [31:0]   w_ld_data;
    logic          w_ack_any;

    // Single requester wins outright; on a tie the port that did not win last time goes.
    assign w_req_any = p0_req | p1_req;
    assign w_sel     = p1_req & (~p0_req | ~r_last_grant);

    assign w_in_we    = w_sel ? p1_we    : p0_we;
    assign w_in_addr  = w_sel ? p1_addr  : p0_addr;
    assign w_in_size  = size_e'(w_sel ? p1_size : p0_size);
    assign w_in_uns   = w_sel ? p1_uns   : p0_uns;
    assign w_in_wdata = w_sel ? p1_wdata : p0_wdata;

    assign w_out_of_range = {2'b00, w_in_addr[31:2]} >= 32'(MEM_DEPTH);
    assign w_illegal      = w_misalign | w_out_of_range;

    dmem_lane_align u_align (
        .i_chk_size (w_in_size),
        .i_chk_off  (w_in_addr[1:0]),
        .o_misalign (w_misalign),
        .i_size     (r_size),
        .i_off      (r_off),
        .i_uns      (r_uns),
        .i_wdata    (r_wdata),
        .o_wstrb    (w_strb),
        .o_wdata    (w_wdata),
        .i_rdata    (mem_rdata),
        .o_rdata    (w_ld_data)
    );

    // r_last_grant doubles as the identity of the port currently being served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_off        <= 2'b00;
            r_size       <= SZ_BYTE;
            r_uns        <= 1'b0;
            r_wdata      <= 32'h0;
            r_err        <= 1'b0;
            r_mem_en     <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update tied to the same clock edge.
            r_mem_en <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_last_grant <= w_sel;
                        r_we         <= w_in_we;
                        r_waddr      <= w_in_addr[AW+1:2];
                        r_off        <= w_in_addr[1:0];
                        r_size       <= w_in_size;
                        r_uns        <= w_in_uns;
                        r_wdata      <= w_in_wdata;
                        r_err        <= w_illegal;
                        if (w_illegal) begin
                            // Rejected requests skip the memory and answer at once.
                            r_state <= ST_RESP;
                            r_ack0  <= ~w_sel;
                            r_ack1  <= w_sel;
                        end else begin
                            r_state  <= ST_ACCESS;
                            r_mem_en <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_state <= ST_RESP;
                    r_ack0  <= ~r_last_grant;
                    r_ack1  <= r_last_grant;
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_ack_any  = r_ack0 | r_ack1;
    assign p0_ack     = r_ack0;
    assign p1_ack     = r_ack1;
    assign resp_err   = w_ack_any & r_err;
    assign resp_rdata = (w_ack_any && !r_we && !r_err) ? w_ld_data : 32'h0;
    assign busy       = (r_state != ST_IDLE);

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_en & r_we;
    assign mem_addr  = r_mem_en ? r_waddr : '0;
    assign mem_wstrb = mem_we ? w_strb  : 4'b0000;
    assign mem_wdata = mem_we ? w_wdata : 32'h0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a byte-strobed word memory model.
module tb_dmem_port_arbiter;

    localparam int MEM_DEPTH = 4096;
    localparam int AW        = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          p0_req = 1'b0, p0_we = 1'b0, p0_uns = 1'b0;
    logic [31:0]   p0_addr = 32'h0, p0_wdata = 32'h0;
    logic [1:0]    p0_size = 2'd0;
    logic          p1_req = 1'b0, p1_we = 1'b0, p1_uns = 1'b0;
    logic [31:0]   p1_addr = 32'h0, p1_wdata = 32'h0;
    logic [1:0]    p1_size = 2'd0;
    logic          p0_ack, p1_ack, resp_err, busy, mem_en, mem_we;
    logic [31:0]   resp_rdata, mem_wdata;
    logic [31:0]   mem_rdata = 32'h0;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wstrb;

    logic [31:0]   tb_mem [0:MEM_DEPTH-1] = '{default: 32'h0};

    int n_checks = 0;
    int n_fail   = 0;

    dmem_port_arbiter #(.MEM_DEPTH(MEM_DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_size(p0_size),
        .p0_uns(p0_uns), .p0_wdata(p0_wdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_size(p1_size),
        .p1_uns(p1_uns), .p1_wdata(p1_wdata), .p1_ack(p1_ack),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory with byte write strobes.
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we && mem_wstrb[b]) tb_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= tb_mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit port, input bit req, input bit we, input logic [31:0] addr,
                         input logic [1:0] size, input bit uns, input logic [31:0] wd);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_size = size; p1_uns = uns; p1_wdata = wd;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_size = size; p0_uns = uns; p0_wdata = wd;
        end
    endtask

    // One complete transaction from a single port, checked at every cycle.
    task automatic xact(input string tag, input bit port, input bit we, input logic [31:0] addr,
                        input logic [1:0] size, input bit uns, input logic [31:0] wd,
                        input bit exp_err, input logic [31:0] exp_maddr, input logic [3:0] exp_strb,
                        input logic [31:0] exp_mwd, input logic [31:0] exp_rd);
        drive(port, 1'b1, we, addr, size, uns, wd);
        tick();
        if (!exp_err) begin
            check({tag, " mem_en"},    32'(mem_en), 1);
            check({tag, " mem_we"},    32'(mem_we), 32'(we));
            check({tag, " mem_addr"},  32'(mem_addr), exp_maddr);
            check({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'(exp_strb));
            check({tag, " mem_wdata"}, mem_wdata, exp_mwd);
            check({tag, " early ack"}, 32'(p0_ack | p1_ack), 0);
            tick();
        end else begin
            check({tag, " mem_en"}, 32'(mem_en), 0);
        end
        check({tag, " ack"},       32'({p1_ack, p0_ack}), port ? 2 : 1);
        check({tag, " resp_err"},  32'(resp_err), 32'(exp_err));
        check({tag, " resp_rdata"}, resp_rdata, exp_rd);
        drive(port, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        tick();
        check({tag, " idle"}, 32'({busy, mem_en, p1_ack, p0_ack}), 0);
    endtask

    initial begin
        // Reset: every output must be zero.
        tick(); tick();
        check("rst ctrl", 32'({p0_ack, p1_ack, resp_err, busy, mem_en, mem_we}), 0);
        check("rst addr", 32'({mem_addr, mem_wstrb}), 0);
        check("rst data", resp_rdata | mem_wdata, 0);
        reset = 1'b0;
        #1;
        check("post-release ctrl", 32'({p0_ack, p1_ack, busy, mem_en}), 0);

        // Stores and loads through both ports.
        xact("sw 0x10",    1'b0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 4, 4'hF, 32'hDEADBEEF, 0);
        check("mem[4] after sw", tb_mem[4], 32'hDEADBEEF);
        xact("lb 0x11",    1'b1, 1'b0, 32'h11, 2'd0, 1'b0, 32'h0, 1'b0, 4, 4'h0, 0, 32'hFFFFFFBE);
        xact("lbu 0x11",   1'b1, 1'b0, 32'h11, 2'd0, 1'b1, 32'h0, 1'b0, 4, 4'h0, 0, 32'h000000BE);
        xact("lhu 0x12",   1'b1, 1'b0, 32'h12, 2'd1, 1'b1, 32'h0, 1'b0, 4, 4'h0, 0, 32'h0000DEAD);
        xact("lh 0x12",    1'b0, 1'b0, 32'h12, 2'd1, 1'b0, 32'h0, 1'b0, 4, 4'h0, 0, 32'hFFFFDEAD);
        xact("sh 0x16",    1'b0, 1'b1, 32'h16, 2'd1, 1'b0, 32'h00001234, 1'b0, 5, 4'hC, 32'h12341234, 0);
        xact("lh 0x16",    1'b1, 1'b0, 32'h16, 2'd1, 1'b0, 32'h0, 1'b0, 5, 4'h0, 0, 32'h00001234);
        xact("sb 0x13",    1'b1, 1'b1, 32'h13, 2'd0, 1'b0, 32'h000000A5, 1'b0, 4, 4'h8, 32'hA5A5A5A5, 0);
        xact("lw 0x10",    1'b0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 1'b0, 4, 4'h0, 0, 32'hA5ADBEEF);
        xact("sw top",     1'b1, 1'b1, 32'h3FFC, 2'd2, 1'b0, 32'h0BADF00D, 1'b0, 32'hFFF, 4'hF, 32'h0BADF00D, 0);
        check("mem[4095] after sw", tb_mem[4095], 32'h0BADF00D);

        // Illegal accesses answer with an error and never touch memory.
        xact("lw 0x12 misaligned", 1'b1, 1'b0, 32'h12,   2'd2, 1'b0, 32'h0, 1'b1, 0, 4'h0, 0, 0);
        xact("sb 0x4000 range",    1'b1, 1'b1, 32'h4000, 2'd0, 1'b0, 32'h77, 1'b1, 0, 4'h0, 0, 0);
        xact("sh 0x11 misaligned", 1'b0, 1'b1, 32'h11,   2'd1, 1'b0, 32'h55, 1'b1, 0, 4'h0, 0, 0);
        xact("size 3",             1'b0, 1'b0, 32'h10,   2'd3, 1'b0, 32'h0,  1'b1, 0, 4'h0, 0, 0);
        check("mem[4] untouched", tb_mem[4], 32'hA5ADBEEF);

        // Request dropped right after grant still completes.
        drive(1'b1, 1'b1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        tick();
        p1_req = 1'b0;
        tick();
        check("early drop ack",   32'({p1_ack, p0_ack}), 2);
        check("early drop rdata", resp_rdata, 32'hA5ADBEEF);
        tick();

        // Both ports requesting continuously from reset: p0 first, then alternate every 3 cycles.
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h14, 2'd2, 1'b0, 32'h0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k % 3 == 0) begin
                check($sformatf("rr k%0d mem_en", k), 32'(mem_en), 1);
                check($sformatf("rr k%0d addr", k), 32'(mem_addr), ((k / 3) % 2) ? 5 : 4);
                check($sformatf("rr k%0d busy", k), 32'(busy), 1);
            end else if (k % 3 == 1) begin
                check($sformatf("rr k%0d ack", k), 32'({p1_ack, p0_ack}), ((k / 3) % 2) ? 2 : 1);
                check($sformatf("rr k%0d rdata", k), resp_rdata,
                      ((k / 3) % 2) ? 32'h12340000 : 32'hA5ADBEEF);
                check($sformatf("rr k%0d busy", k), 32'(busy), 1);
            end else begin
                check($sformatf("rr k%0d idle", k), 32'({busy, mem_en, p1_ack, p0_ack}), 0);
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        tick();

        // Reset during ACCESS of a store: write is lost, FSM returns to IDLE.
        drive(1'b0, 1'b1, 1'b1, 32'h14, 2'd2, 1'b0, 32'hCAFEF00D);
        tick();
        check("abort mem_en before", 32'(mem_en), 1);
        reset = 1'b1;
        #1;
        check("abort outputs", 32'({mem_en, mem_we, p0_ack, p1_ack, busy}), 0);
        p0_req = 1'b0;
        tick();
        reset = 1'b0;
        check("abort mem[5]", tb_mem[5], 32'h12340000);
        tick();
        check("abort idle", 32'({busy, mem_en, p0_ack, p1_ack}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
